// File: rtl/tpu_result_drain.sv
// Drains result SRAM rows, requantizes each lane to OUT_BW bits, and streams
// the rows out through valid/ready with a 2-entry skid FIFO.
module tpu_result_drain #(
    parameter int MATRIX_SIZE    = 16,
    parameter int PARTIAL_SUM_BW = 24,
    parameter int OUT_BW         = 8,
    parameter int ADDRESSSIZE    = 10,
    parameter int NUM_ROWS       = 16
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               start,
    input  logic [ADDRESSSIZE-1:0]             base_addr,
    input  logic [4:0]                         shift_amt,
    input  logic                               relu_en,
    output logic                               sram_rd_en,
    output logic [ADDRESSSIZE-1:0]             sram_rd_addr,
    input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] sram_rd_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [OUT_BW*MATRIX_SIZE-1:0]      out_data,
    output logic                               out_last,
    output logic                               busy,
    output logic                               done
);

    localparam int LW = OUT_BW * MATRIX_SIZE;
    localparam int PW = $clog2(NUM_ROWS);
    localparam int EW = PARTIAL_SUM_BW + 2;
    localparam logic signed [EW-1:0] SAT_HI = EW'((1 << (OUT_BW - 1)) - 1);
    localparam logic signed [EW-1:0] SAT_LO = ~SAT_HI;

    typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;

    state_t state, state_nx;

    logic [ADDRESSSIZE-1:0] cur_addr, last_addr;
    logic [PW-1:0]          rd_ptr;
    logic [4:0]             shift_q;
    logic                   relu_q;
    logic                   inflight, inflight_last;
    logic                   issue, push, pop;
    logic [2:0]             credit;

    logic [LW-1:0]          fifo_data [2];
    logic                   fifo_last [2];
    logic                   rd_idx, wr_idx;
    logic [1:0]             fifo_count;

    logic [LW-1:0]          rq_data;
    logic signed [EW-1:0]   lane_x, lane_r, lane_y;

    assign out_valid    = (fifo_count != 2'd0);
    assign pop          = out_valid & out_ready;
    assign push         = inflight;
    assign out_data     = out_valid ? fifo_data[rd_idx] : '0;
    assign out_last     = out_valid & fifo_last[rd_idx];
    assign credit       = 3'(inflight) + 3'(fifo_count) - 3'(pop);
    assign sram_rd_en   = issue;
    assign sram_rd_addr = issue ? cur_addr : last_addr;
    assign busy         = (state == READ) || (state == FLUSH);
    assign done         = (state == DONE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        unique case (state)
            IDLE: if (start) state_nx = READ;
            READ: begin
                issue = (credit < 3'd2);
                if (issue && rd_ptr == PW'(NUM_ROWS - 1)) state_nx = FLUSH;
            end
            FLUSH: if (!inflight && fifo_count == 2'(pop)) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Round-half-up arithmetic shift, then signed saturation, per lane
    always_comb begin
        rq_data = '0;
        lane_x  = '0;
        lane_r  = '0;
        lane_y  = '0;
        for (int i = 0; i < MATRIX_SIZE; i++) begin
            lane_x = EW'($signed(sram_rd_data[i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW]));
            if (relu_q && lane_x < 0) lane_x = '0;
            lane_r = EW'(1) << (shift_q - 5'd1);
            lane_y = (shift_q != 5'd0) ? ((lane_x + lane_r) >>> shift_q) : lane_x;
            if (lane_y > SAT_HI)      lane_y = SAT_HI;
            else if (lane_y < SAT_LO) lane_y = SAT_LO;
            rq_data[i*OUT_BW +: OUT_BW] = lane_y[OUT_BW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cur_addr      <= '0;
            last_addr     <= '0;
            rd_ptr        <= '0;
            shift_q       <= '0;
            relu_q        <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight <= issue;
            if (state == IDLE && start) begin
                shift_q  <= shift_amt;
                relu_q   <= relu_en;
                cur_addr <= base_addr;
                rd_ptr   <= '0;
            end
            if (issue) begin
                inflight_last <= (rd_ptr == PW'(NUM_ROWS - 1));
                last_addr     <= cur_addr;
                cur_addr      <= cur_addr + 1'b1;
                rd_ptr        <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_last[0] <= 1'b0;
            fifo_last[1] <= 1'b0;
            rd_idx       <= 1'b0;
            wr_idx       <= 1'b0;
            fifo_count   <= '0;
        end else begin
            if (push) begin
                fifo_data[wr_idx] <= rq_data;
                fifo_last[wr_idx] <= inflight_last;
                wr_idx            <= ~wr_idx;
            end
            if (pop) rd_idx <= ~rd_idx;
            fifo_count <= fifo_count + 2'(push) - 2'(pop);
        end
    end

endmodule
